// File: rtl/vend_disp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vend_disp_pkg : shared constants for the 4-digit display driver  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package vend_disp_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment vector is active-low, ordered g f e d c b a (bit0 = a)
  localparam int SEG_A_BIT = 0;
  localparam int SEG_G_BIT = 6;
  localparam int SEG_W     = SEG_G_BIT - SEG_A_BIT + 1;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/vend_disp_scan_bcd_to_7seg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_to_7seg : BCD digit to active-low segment pattern, with blank |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module bcd_to_7seg
  import vend_disp_pkg::*;
(
  input  logic [3:0]       bcd,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/vend_disp_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vend_disp_scan : 4-digit 7-seg scan driver with load, LZB, blink  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module vend_disp_scan
  import vend_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lzb_en,
  input  logic                    blink_en,
  output logic [SEG_W-1:0]        seg_x1,
  output logic [SEG_W-1:0]        seg_x2,
  output logic [SEG_W-1:0]        seg_x3,
  output logic [SEG_W-1:0]        seg_x4,
  output logic [1:0]              sel,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] c_presc_last = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] c_frame_last = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]              r_presc;
  logic [1:0]                 r_sel;
  logic [NUM_DIGITS-1:0]      r_an;
  logic                       r_pend;
  logic [4*NUM_DIGITS-1:0]    r_pend_val;
  logic [4*NUM_DIGITS-1:0]    r_active;
  logic                       r_phase;
  logic [FW-1:0]              r_frame_cnt;
  logic [SEG_W-1:0]           r_seg [NUM_DIGITS];

  logic [SEG_W-1:0]           w_seg [NUM_DIGITS];
  logic                       w_tick;
  logic                       w_frame;
  logic                       w_phase_nxt;
  logic [1:0]                 w_sel_nxt;
  logic [NUM_DIGITS-1:0]      w_blank;
  logic [NUM_DIGITS-1:0]      w_an_nxt;

  assign w_tick      = (r_presc == c_presc_last);
  assign w_frame     = w_tick && (r_sel == 2'd3);
  assign w_sel_nxt   = w_tick ? r_sel + 2'd1 : r_sel;
  assign w_phase_nxt = (w_frame && (r_frame_cnt == c_frame_last)) ? ~r_phase : r_phase;

  // A digit is blanked while it and every digit to its left are zero
  always_comb begin : p_blank
    logic lead;
    lead    = lzb_en;
    w_blank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lead       = lead && (r_active[4*k +: 4] == 4'd0);
      w_blank[k] = lead;
    end
  end

  // Anodes track the post-edge select so sel and an move together
  assign w_an_nxt = (w_blank[w_sel_nxt] || (blink_en && w_phase_nxt))
                  ? '1 : ~(NUM_DIGITS'(1) << w_sel_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_sel       <= 2'd0;
      r_an        <= '1;
      r_phase     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_sel   <= w_sel_nxt;
      r_an    <= w_an_nxt;
      r_phase <= w_phase_nxt;
      if (w_frame) begin
        r_frame_cnt <= (r_frame_cnt == c_frame_last) ? '0 : r_frame_cnt + FW'(1);
      end
    end
  end

  // Values land in the pending register and only reach the display at a frame edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_active   <= '0;
    end else if (r_pend) begin
      if (w_frame) begin
        r_active <= r_pend_val;
        r_pend   <= 1'b0;
      end
    end else if (load_valid) begin
      r_pend_val <= digits_in;
      r_pend     <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    bcd_to_7seg u_dec (
      .bcd   (r_active[4*k +: 4]),
      .blank (w_blank[k]),
      .seg   (w_seg[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) r_seg[k] <= SEG_BLANK;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) r_seg[k] <= w_seg[k];
    end
  end

  assign load_ready = !r_pend;
  assign sel        = r_sel;
  assign an         = r_an;
  assign seg_x1     = r_seg[0];
  assign seg_x2     = r_seg[1];
  assign seg_x3     = r_seg[2];
  assign seg_x4     = r_seg[3];

endmodule
`default_nettype wire

// File: tb/tb_vend_disp_scan.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_vend_disp_scan : scoreboard bench for vend_disp_scan           |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_vend_disp_scan;

  localparam int RD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        lzb_en = 1'b0;
  logic        blink_en = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        load_ready;
  logic [6:0]  seg_x1, seg_x2, seg_x3, seg_x4;
  logic [1:0]  sel;
  logic [3:0]  an;

  always #5 clk = ~clk;

  vend_disp_scan #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digits_in  (digits_in),
    .lzb_en     (lzb_en),
    .blink_en   (blink_en),
    .seg_x1     (seg_x1),
    .seg_x2     (seg_x2),
    .seg_x3     (seg_x3),
    .seg_x4     (seg_x4),
    .sel        (sel),
    .an         (an)
  );

  typedef struct packed {
    logic [6:0] s1, s2, s3, s4;
    logic [1:0] sel;
    logic [3:0] an;
    logic       rdy;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  logic [6:0] ref_pat [16];

  initial begin
    ref_pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  end

  function automatic bit blanked(logic [15:0] v, bit lzb, int k);
    if (!lzb || k == 0) return 1'b0;
    for (int j = k; j < 4; j++) if (v[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [6:0] pat(logic [15:0] v, bit lzb, int k);
    if (blanked(v, lzb, k)) return 7'b1111111;
    return ref_pat[v[4*k +: 4]];
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.s1 = 7'h7f; e.s2 = 7'h7f; e.s3 = 7'h7f; e.s4 = 7'h7f;
    e.sel = 2'd0; e.an = 4'hf; e.rdy = 1'b1;
    return e;
  endfunction

  // Reference model: state after the n-th clock edge since reset release
  int          n;
  bit          m_pend;
  logic [15:0] m_pval, m_act;

  always @(posedge clk) begin : p_model
    exp_t       e;
    int         s;
    int         ph;
    logic [3:0] one;
    one = 4'b0001;
    if (!rst_n) begin
      n = 0; m_pend = 1'b0; m_pval = '0; m_act = '0;
      q.push_back(reset_exp());
    end else begin
      n++;
      s  = (n / RD) % 4;
      ph = ((n / FRAME) / BF) % 2;
      e.s1  = pat(m_act, lzb_en, 0);
      e.s2  = pat(m_act, lzb_en, 1);
      e.s3  = pat(m_act, lzb_en, 2);
      e.s4  = pat(m_act, lzb_en, 3);
      e.sel = s[1:0];
      e.an  = ((blink_en && ph == 1) || blanked(m_act, lzb_en, s)) ? 4'hf : ~(one << s);
      if (m_pend && (n % FRAME == 0)) begin
        m_act  = m_pval;
        m_pend = 1'b0;
      end else if (!m_pend && load_valid) begin
        m_pval = digits_in;
        m_pend = 1'b1;
      end
      e.rdy = !m_pend;
      q.push_back(e);
    end
  end

  task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : p_monitor
    exp_t e;
    bit   have;
    have = 1'b1;
    if (!rst_n) begin
      if (q.size() > 0) void'(q.pop_front());
      e = reset_exp();
    end else if (q.size() == 0) begin
      checks++; failures++;
      have = 1'b0;
      $display("FAIL scoreboard_empty actual=0 required=1 t=%0t", $time);
    end else begin
      e = q.pop_front();
    end
    if (have) begin
      cmp("seg_x1", 16'(seg_x1), 16'(e.s1));
      cmp("seg_x2", 16'(seg_x2), 16'(e.s2));
      cmp("seg_x3", 16'(seg_x3), 16'(e.s3));
      cmp("seg_x4", 16'(seg_x4), 16'(e.s4));
      cmp("sel", 16'(sel), 16'(e.sel));
      cmp("an", 16'(an), 16'(e.an));
      cmp("load_ready", 16'(load_ready), 16'(e.rdy));
    end
  end

  task automatic offer(logic [15:0] v);
    bit r;
    load_valid = 1'b1;
    digits_in  = v;
    for (int i = 0; i < 200; i++) begin
      r = load_ready;
      @(posedge clk); #1;
      if (r) break;
    end
    load_valid = 1'b0;
  endtask

  task automatic wait_cyc(int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rnd_nib();
    int r;
    r = $urandom_range(0, 15);
    if (r < 6) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    offer(16'h1234);
    wait_cyc(2 * FRAME);
    lzb_en = 1'b1;
    offer(16'h0050);
    wait_cyc(2 * FRAME);
    offer(16'h00A0);
    wait_cyc(2 * FRAME);
    lzb_en   = 1'b0;
    blink_en = 1'b1;
    wait_cyc(6 * FRAME);
    blink_en = 1'b0;
    wait_cyc(5);
    // back-to-back offers: the second waits while the first is pending
    offer(16'h4321);
    load_valid = 1'b1; digits_in = 16'h8888;
    wait_cyc(3);
    offer(16'h8888);
    wait_cyc(2 * FRAME);
    offer(16'h5678);
    wait_cyc(2);
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2 * FRAME);
    for (int c = 0; c < 3000; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      digits_in  = {rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib()};
      if ($urandom_range(0, 63) == 0) lzb_en = ~lzb_en;
      if ($urandom_range(0, 127) == 0) blink_en = ~blink_en;
      wait_cyc(1);
    end
    load_valid = 1'b0;
    wait_cyc(3);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
